vec_data_mem: RTL

Data-memory responder for the pipelined ARM core's memory stage. It serves single-cycle scalar word reads and writes, and 9-element signed vector loads and stores. Vector accesses are serialized over one 32-bit RAM port, and a stall is raised to the hazard unit while they run. It answers the `ALUResultM` / `WriteData` / `MemWriteM` / `ReadData` and `WriteDataV` / `ReadDataV` / `MemWriteVM` signals driven by the datapath.

---
 rtl/vec_data_mem_if.sv | 28 ++
 rtl/vec_data_mem.sv | 134 +++++++++++++
 2 files changed

// File: rtl/vec_data_mem_if.sv
// Memory-stage bus between the datapath and vec_data_mem:
// scalar word access plus serialized signed vector load/store.
interface vec_data_mem_if #(
  parameter int VLEN = 9,
  parameter int EW   = 9
);
  logic [31:0]                ALUResultM;
  logic [31:0]                WriteData;
  logic                       MemWriteM;
  logic [31:0]                ReadData;
  logic [VLEN-1:0][EW-1:0]    WriteDataV;
  logic                       MemWriteVM;
  logic                       MemReadVM;
  logic [VLEN-1:0][EW-1:0]    ReadDataV;
  logic                       StallMem;

  modport master (
    output ALUResultM, WriteData, MemWriteM,
    output WriteDataV, MemWriteVM, MemReadVM,
    input  ReadData, ReadDataV, StallMem
  );

  modport slave (
    input  ALUResultM, WriteData, MemWriteM,
    input  WriteDataV, MemWriteVM, MemReadVM,
    output ReadData, ReadDataV, StallMem
  );
endinterface

// File: rtl/vec_data_mem.sv
// Data memory with single-cycle scalar access and serialized vector ops.
// Define VEC_DATA_MEM_PERF_EN to build the performance counters.
module vec_data_mem #(
  parameter int DEPTH = 256,
  parameter int VLEN  = 9,
  parameter int EW    = 9
) (
  input  logic          clk,
  input  logic          reset,
  vec_data_mem_if.slave bus,
  output logic [15:0]   PerfScalarWr,
  output logic [15:0]   PerfVecOps,
  output logic [15:0]   PerfStallCyc
);

  localparam int AW = $clog2(DEPTH);
  localparam int IW = (VLEN > 1) ? $clog2(VLEN) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t                  state;
  logic [IW-1:0]           idx;
  logic [AW-1:0]           base;
  logic                    opWr;
  logic [VLEN-1:0][EW-1:0] vecBuf;
  logic [VLEN-1:0][EW-1:0] rdVec;

  logic [31:0] mem [DEPTH];

  logic [AW-1:0] wordIdx;
  logic [AW-1:0] elemAddr;
  logic [31:0]   elemData;
  logic          vecReq;
  logic          lastIdx;
  logic          scalarWr;
  logic          vecWr;
  logic          unusedAddr;

  assign wordIdx  = bus.ALUResultM[AW+1:2];
  assign elemAddr = base + AW'(idx);
  assign elemData = 32'(signed'(vecBuf[idx]));
  assign vecReq   = bus.MemWriteVM | bus.MemReadVM;
  assign lastIdx  = (idx == IW'(VLEN - 1));

  assign unusedAddr = ^{bus.ALUResultM[31:AW+2],
                        bus.ALUResultM[1:0]};

  // A vector request in the same cycle swallows the scalar write.
  assign scalarWr = reset & (state == IDLE) &
                    ~vecReq & bus.MemWriteM;
  assign vecWr    = reset & (state == BUSY) & opWr;

  always_ff @(posedge clk) begin
    if (scalarWr)
      mem[wordIdx] <= bus.WriteData;
    else if (vecWr)
      mem[elemAddr] <= elemData;
  end

  assign bus.ReadData  = mem[wordIdx];
  assign bus.ReadDataV = rdVec;

  assign bus.StallMem = reset &
    (((state == IDLE) & vecReq) | (state == BUSY));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      idx    <= '0;
      base   <= '0;
      opWr   <= 1'b0;
      vecBuf <= '0;
      rdVec  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (vecReq) begin
            base   <= wordIdx;
            vecBuf <= bus.WriteDataV;
            opWr   <= bus.MemWriteVM;
            idx    <= '0;
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (!opWr)
            rdVec[idx] <= mem[elemAddr][EW-1:0];
          if (lastIdx) begin
            idx   <= '0;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef VEC_DATA_MEM_PERF_EN
  logic [15:0] cntSw;
  logic [15:0] cntVo;
  logic [15:0] cntSc;
  logic        vecDone;

  assign vecDone = (state == BUSY) & lastIdx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cntSw <= '0;
      cntVo <= '0;
      cntSc <= '0;
    end else begin
      cntSw <= cntSw + 16'(scalarWr);
      cntVo <= cntVo + 16'(vecDone);
      cntSc <= cntSc + 16'(bus.StallMem);
    end
  end

  assign PerfScalarWr = cntSw;
  assign PerfVecOps   = cntVo;
  assign PerfStallCyc = cntSc;
`else
  assign PerfScalarWr = '0;
  assign PerfVecOps   = '0;
  assign PerfStallCyc = '0;
`endif

endmodule
